fft_in_buffer: RTL and testbench
================================

FFT_IN_BUFFER -- requirements
Module: fft_in_buffer

Interface
REQ-001 SHALL have parameter WORD_LEN, default 11, giving the width of each real or imaginary part.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port MemIn, input, 2*WORD_LEN bits: one complex sample {re, im}, natural order.
REQ-005 SHALL have port in_valid, input, 1 bit: MemIn is valid and is accepted on this rising edge.
REQ-006 SHALL have port MemOutUp, output, 2*WORD_LEN bits: sample x[k] of the current output frame.
REQ-007 SHALL have port MemOutDown, output, 2*WORD_LEN bits: sample x[k+16] of the current output frame.
REQ-008 SHALL have port out_valid, output, 1 bit: MemOutUp and MemOutDown are valid this cycle.
REQ-009 SHALL have port out_last, output, 1 bit: high together with out_valid on pair k=15 only.

Function
REQ-010 SHALL store frames in two 32-entry banks (A, B) of 2*WORD_LEN bits each, used ping-pong.
REQ-011 SHALL use a 5-bit input counter: each accepted sample is written to write-bank[cnt], then cnt increments, wrapping 31 -> 0.
REQ-012 SHALL hold the input counter, and write nothing, on cycles with in_valid=0; gaps of any length are legal.
REQ-013 SHALL toggle the write bank and set a 1-bit pending flag on the edge that accepts entry 31.
REQ-014 SHALL use two states: IDLE and OUTPUT.
REQ-015 SHALL go IDLE -> OUTPUT when pending=1; that transition clears pending, latches read bank = the just-filled bank, and sets the 4-bit output counter k=0.
REQ-016 SHALL, in OUTPUT, drive out_valid=1, MemOutUp=read-bank[k], MemOutDown=read-bank[k+16], then increment k every cycle; no stall is provided.
REQ-017 SHALL, at k=15 in OUTPUT, go to IDLE if pending=0, or stay in OUTPUT if pending=1, clearing pending and restarting at k=0 on the other bank with no bubble.
REQ-018 SHALL assert out_valid for the first time exactly 1 cycle after the edge that accepts sample 31: latency = 1 cycle from the last input, 16 output cycles per frame.
REQ-019 SHALL handle pending being set and cleared on the same edge by leaving pending=1.
REQ-020 SHALL let writes to the write bank proceed during output of the read bank; a frame (>=32 cycles) cannot overrun an output (16 cycles).
REQ-021 SHALL drive outputs from registers and the counter only, with no combinational path from MemIn or in_valid.
REQ-022 SHALL drive MemOutUp/MemOutDown to 0 when out_valid=0.

Reset
REQ-023 SHALL, when i_rst=1 at a rising edge, clear state to IDLE and clear counters, bank selects (A for both write and read), pending and both banks to 0.
REQ-024 SHALL hold out_valid, out_last, MemOutUp and MemOutDown at 0 after reset.
REQ-025 SHALL discard any partial input frame or in-progress output on reset mid-operation, and accept the next sample after reset as entry 0.
REQ-026 SHALL ignore in_valid on a reset edge.

Verification
REQ-027 SHALL cover single frame: 32 consecutive samples re=n, im=0 (n=0..31) -> out_valid high 16 cycles starting 1 cycle after sample 31; cycle k: Up re=k, Down re=k+16; out_last only at k=15.
REQ-028 SHALL cover back-to-back: 3 frames (re=n, 32+n, 64+n) fed continuously -> 3 bursts of 16 pairs, each burst correct for its frame, banks alternating A/B/A.
REQ-029 SHALL cover gapped input: one frame with in_valid=0 on every 3rd cycle -> output identical to REQ-027, starting 1 cycle after the last accepted sample.
REQ-030 SHALL cover reset mid-input: 20 samples, then i_rst for 1 cycle, then 32 samples re=100+n -> no output before the new frame; output Up re=100+k, Down re=116+k.
REQ-031 SHALL cover reset mid-output: i_rst asserted at k=7 -> out_valid=0 and outputs 0 on the next cycle; out_valid stays 0 until a full new frame arrives.

Source files
------------

// File: rtl/fft_in_buffer.sv
// Input reorder buffer for a 32-point FFT: ping-pong banks filled in natural order,
// drained as 16 butterfly pairs x[k] / x[k+16] per frame.
module fft_in_buffer #(
    parameter int WORD_LEN = 11
) (
    input  logic                    clk,
    input  logic                    i_rst,
    input  logic [2*WORD_LEN-1:0]   MemIn,
    input  logic                    in_valid,
    output logic [2*WORD_LEN-1:0]   MemOutUp,
    output logic [2*WORD_LEN-1:0]   MemOutDown,
    output logic                    out_valid,
    output logic                    out_last
);

    typedef enum logic {
        IDLE,
        OUTPUT
    } state_t;

    state_t state, state_nxt;

    logic [2*WORD_LEN-1:0] bank_a [32];
    logic [2*WORD_LEN-1:0] bank_b [32];

    logic [4:0] wr_cnt;
    logic       wr_sel;
    logic       rd_sel;
    logic       pending;
    logic [3:0] k;
    logic       start;
    logic       fill_done;

    assign fill_done = in_valid && (wr_cnt == 5'd31);

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // start marks the edge that begins a new 16-pair burst, including the seamless restart
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    state_nxt = OUTPUT;
                    start     = 1'b1;
                end
            end
            OUTPUT: begin
                if (k == 4'd15) begin
                    if (pending) begin
                        start = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            wr_cnt  <= '0;
            wr_sel  <= 1'b0;
            rd_sel  <= 1'b0;
            pending <= 1'b0;
            k       <= '0;
            bank_a  <= '{default: '0};
            bank_b  <= '{default: '0};
        end else begin
            if (in_valid) begin
                if (wr_sel) begin
                    bank_b[wr_cnt] <= MemIn;
                end else begin
                    bank_a[wr_cnt] <= MemIn;
                end
                wr_cnt <= wr_cnt + 5'd1;
            end
            if (fill_done) begin
                wr_sel <= ~wr_sel;
            end
            // a completing frame wins over a consuming burst start
            if (fill_done) begin
                pending <= 1'b1;
            end else if (start) begin
                pending <= 1'b0;
            end
            if (start) begin
                rd_sel <= ~wr_sel;
                k      <= '0;
            end else if (state == OUTPUT) begin
                k <= k + 4'd1;
            end
        end
    end

    always_comb begin
        out_valid  = (state == OUTPUT);
        out_last   = out_valid && (k == 4'd15);
        MemOutUp   = '0;
        MemOutDown = '0;
        if (out_valid) begin
            if (rd_sel) begin
                MemOutUp   = bank_b[{1'b0, k}];
                MemOutDown = bank_b[{1'b1, k}];
            end else begin
                MemOutUp   = bank_a[{1'b0, k}];
                MemOutDown = bank_a[{1'b1, k}];
            end
        end
    end

endmodule

// File: tb/tb_fft_in_buffer.sv
// Scoreboard bench for fft_in_buffer: expected pairs queued as frames are fed,
// observed pairs queued by a negedge monitor, compared per scenario.
module tb_fft_in_buffer;

    localparam int W = 11;

    logic           clk = 1'b0;
    logic           i_rst;
    logic           in_valid;
    logic [2*W-1:0] MemIn;
    logic [2*W-1:0] MemOutUp;
    logic [2*W-1:0] MemOutDown;
    logic           out_valid;
    logic           out_last;

    typedef struct packed {
        logic [2*W-1:0] up;
        logic [2*W-1:0] down;
        logic           last;
    } pair_t;

    pair_t exp_q[$];
    pair_t obs_q[$];
    int    exp_start_q[$];
    int    obs_start_q[$];

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;
    int idle_bad = 0;
    bit prev_valid = 1'b0;
    bit prev_last  = 1'b0;

    fft_in_buffer #(.WORD_LEN(W)) dut (
        .clk       (clk),
        .i_rst     (i_rst),
        .MemIn     (MemIn),
        .in_valid  (in_valid),
        .MemOutUp  (MemOutUp),
        .MemOutDown(MemOutDown),
        .out_valid (out_valid),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            obs_q.push_back(pair_t'{MemOutUp, MemOutDown, out_last});
            if (!prev_valid || prev_last) obs_start_q.push_back(edge_cnt);
        end else if (out_last !== 1'b0 || MemOutUp !== '0 || MemOutDown !== '0) begin
            idle_bad++;
        end
        prev_valid = (out_valid === 1'b1);
        prev_last  = (out_last === 1'b1);
    end

    function automatic logic [2*W-1:0] mk(input int re);
        return {W'(re), W'(0)};
    endfunction

    task automatic clear_sb();
        exp_q.delete();
        obs_q.delete();
        exp_start_q.delete();
        obs_start_q.delete();
        idle_bad = 0;
    endtask

    task automatic do_reset();
        i_rst    = 1'b1;
        in_valid = 1'b1;
        MemIn    = mk(999);
        @(posedge clk);
        #1;
        i_rst    = 1'b0;
        in_valid = 1'b0;
        MemIn    = '0;
    endtask

    task automatic feed_frame(input int base, input int count, input bit gap);
        pair_t p;
        for (int n = 0; n < count; n++) begin
            if (gap && n > 0 && (n % 2) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            MemIn    = mk(base + n);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (count == 32) begin
            exp_start_q.push_back(edge_cnt + 1);
            for (int j = 0; j < 16; j++) begin
                p.up   = mk(base + j);
                p.down = mk(base + 16 + j);
                p.last = (j == 15);
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic wait_drain(output bit timed_out);
        for (int t = 0; t < 300 && obs_q.size() < exp_q.size(); t++) @(posedge clk);
        timed_out = (obs_q.size() < exp_q.size());
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        clear_sb();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid: got %b, need 0", out_valid);
        end
        checks++;
        if (out_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_last: got %b, need 0", out_last);
        end
        checks++;
        if (MemOutUp !== '0) begin
            failures++;
            $display("FAIL reset_up: got %h, need 0", MemOutUp);
        end
        checks++;
        if (MemOutDown !== '0) begin
            failures++;
            $display("FAIL reset_down: got %h, need 0", MemOutDown);
        end
    endtask

    task automatic test_single_frame();
        bit to;
        pair_t e, o;
        int es, os;
        feed_frame(0, 32, 1'b0);
        wait_drain(to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL single_timeout: got %0d pairs, need %0d", obs_q.size(), exp_q.size());
        end
        checks++;
        if (obs_q.size() !== exp_q.size() || obs_start_q.size() !== exp_start_q.size()) begin
            failures++;
            $display("FAIL single_count: got %0d pairs/%0d bursts, need %0d/%0d",
                     obs_q.size(), obs_start_q.size(), exp_q.size(), exp_start_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL single_pair: got up=%h down=%h last=%b, need up=%h down=%h last=%b",
                         o.up, o.down, o.last, e.up, e.down, e.last);
            end
        end
        while (exp_start_q.size() > 0 && obs_start_q.size() > 0) begin
            es = exp_start_q.pop_front();
            os = obs_start_q.pop_front();
            checks++;
            if (os !== es) begin
                failures++;
                $display("FAIL single_latency: got first valid at edge %0d, need %0d", os, es);
            end
        end
        checks++;
        if (idle_bad !== 0) begin
            failures++;
            $display("FAIL single_idle_zero: got %0d bad idle cycles, need 0", idle_bad);
        end
        clear_sb();
    endtask

    task automatic test_back_to_back();
        bit to;
        pair_t e, o;
        int es, os;
        feed_frame(0, 32, 1'b0);
        feed_frame(32, 32, 1'b0);
        feed_frame(64, 32, 1'b0);
        wait_drain(to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL b2b_timeout: got %0d pairs, need %0d", obs_q.size(), exp_q.size());
        end
        checks++;
        if (obs_q.size() !== exp_q.size() || obs_start_q.size() !== exp_start_q.size()) begin
            failures++;
            $display("FAIL b2b_count: got %0d pairs/%0d bursts, need %0d/%0d",
                     obs_q.size(), obs_start_q.size(), exp_q.size(), exp_start_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL b2b_pair: got up=%h down=%h last=%b, need up=%h down=%h last=%b",
                         o.up, o.down, o.last, e.up, e.down, e.last);
            end
        end
        while (exp_start_q.size() > 0 && obs_start_q.size() > 0) begin
            es = exp_start_q.pop_front();
            os = obs_start_q.pop_front();
            checks++;
            if (os !== es) begin
                failures++;
                $display("FAIL b2b_latency: got burst start at edge %0d, need %0d", os, es);
            end
        end
        checks++;
        if (idle_bad !== 0) begin
            failures++;
            $display("FAIL b2b_idle_zero: got %0d bad idle cycles, need 0", idle_bad);
        end
        clear_sb();
    endtask

    task automatic test_gapped();
        bit to;
        pair_t e, o;
        int es, os;
        feed_frame(0, 32, 1'b1);
        wait_drain(to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL gap_timeout: got %0d pairs, need %0d", obs_q.size(), exp_q.size());
        end
        checks++;
        if (obs_q.size() !== exp_q.size() || obs_start_q.size() !== exp_start_q.size()) begin
            failures++;
            $display("FAIL gap_count: got %0d pairs/%0d bursts, need %0d/%0d",
                     obs_q.size(), obs_start_q.size(), exp_q.size(), exp_start_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL gap_pair: got up=%h down=%h last=%b, need up=%h down=%h last=%b",
                         o.up, o.down, o.last, e.up, e.down, e.last);
            end
        end
        while (exp_start_q.size() > 0 && obs_start_q.size() > 0) begin
            es = exp_start_q.pop_front();
            os = obs_start_q.pop_front();
            checks++;
            if (os !== es) begin
                failures++;
                $display("FAIL gap_latency: got first valid at edge %0d, need %0d", os, es);
            end
        end
        checks++;
        if (idle_bad !== 0) begin
            failures++;
            $display("FAIL gap_idle_zero: got %0d bad idle cycles, need 0", idle_bad);
        end
        clear_sb();
    endtask

    task automatic test_reset_mid_input();
        bit to;
        pair_t e, o;
        int es, os;
        feed_frame(0, 20, 1'b0);
        do_reset();
        feed_frame(100, 32, 1'b0);
        wait_drain(to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL rstin_timeout: got %0d pairs, need %0d", obs_q.size(), exp_q.size());
        end
        checks++;
        if (obs_q.size() !== exp_q.size() || obs_start_q.size() !== exp_start_q.size()) begin
            failures++;
            $display("FAIL rstin_count: got %0d pairs/%0d bursts, need %0d/%0d",
                     obs_q.size(), obs_start_q.size(), exp_q.size(), exp_start_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL rstin_pair: got up=%h down=%h last=%b, need up=%h down=%h last=%b",
                         o.up, o.down, o.last, e.up, e.down, e.last);
            end
        end
        while (exp_start_q.size() > 0 && obs_start_q.size() > 0) begin
            es = exp_start_q.pop_front();
            os = obs_start_q.pop_front();
            checks++;
            if (os !== es) begin
                failures++;
                $display("FAIL rstin_latency: got first valid at edge %0d, need %0d", os, es);
            end
        end
        checks++;
        if (idle_bad !== 0) begin
            failures++;
            $display("FAIL rstin_idle_zero: got %0d bad idle cycles, need 0", idle_bad);
        end
        clear_sb();
    endtask

    task automatic test_reset_mid_output();
        bit to;
        pair_t e, o;
        int es, os;
        feed_frame(0, 32, 1'b0);
        // pair k=7 is on the outputs after 8 more edges; reset is sampled on the next one
        repeat (8) @(posedge clk);
        #1;
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || MemOutUp !== '0 || MemOutDown !== '0 || out_last !== 1'b0) begin
            failures++;
            $display("FAIL rstout_cut: got valid=%b last=%b up=%h down=%h, need all 0",
                     out_valid, out_last, MemOutUp, MemOutDown);
        end
        while (exp_q.size() > 8) void'(exp_q.pop_back());
        checks++;
        if (obs_q.size() !== exp_q.size() || obs_start_q.size() !== exp_start_q.size()) begin
            failures++;
            $display("FAIL rstout_count: got %0d pairs/%0d bursts, need %0d/%0d",
                     obs_q.size(), obs_start_q.size(), exp_q.size(), exp_start_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL rstout_pair: got up=%h down=%h last=%b, need up=%h down=%h last=%b",
                         o.up, o.down, o.last, e.up, e.down, e.last);
            end
        end
        while (exp_start_q.size() > 0 && obs_start_q.size() > 0) begin
            es = exp_start_q.pop_front();
            os = obs_start_q.pop_front();
            checks++;
            if (os !== es) begin
                failures++;
                $display("FAIL rstout_latency: got first valid at edge %0d, need %0d", os, es);
            end
        end
        clear_sb();
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (obs_q.size() !== 0 || idle_bad !== 0) begin
            failures++;
            $display("FAIL rstout_quiet: got %0d pairs and %0d bad idle cycles, need 0/0",
                     obs_q.size(), idle_bad);
        end
        clear_sb();
        feed_frame(300, 32, 1'b0);
        wait_drain(to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL rstout_new_timeout: got %0d pairs, need %0d", obs_q.size(), exp_q.size());
        end
        checks++;
        if (obs_q.size() !== exp_q.size() || obs_start_q.size() !== exp_start_q.size()) begin
            failures++;
            $display("FAIL rstout_new_count: got %0d pairs/%0d bursts, need %0d/%0d",
                     obs_q.size(), obs_start_q.size(), exp_q.size(), exp_start_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL rstout_new_pair: got up=%h down=%h last=%b, need up=%h down=%h last=%b",
                         o.up, o.down, o.last, e.up, e.down, e.last);
            end
        end
        while (exp_start_q.size() > 0 && obs_start_q.size() > 0) begin
            es = exp_start_q.pop_front();
            os = obs_start_q.pop_front();
            checks++;
            if (os !== es) begin
                failures++;
                $display("FAIL rstout_new_latency: got first valid at edge %0d, need %0d", os, es);
            end
        end
        checks++;
        if (idle_bad !== 0) begin
            failures++;
            $display("FAIL rstout_idle_zero: got %0d bad idle cycles, need 0", idle_bad);
        end
        clear_sb();
    endtask

    initial begin
        i_rst    = 1'b1;
        in_valid = 1'b0;
        MemIn    = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_gapped();
        test_reset_mid_input();
        test_reset_mid_output();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
